// File: rtl/conv_window_fetch.sv
// Fetches ROWS-pixel columns from the pixel ROM; a column is valid ROWS+ROM_LATENCY cycles after its fetch starts.
// While o_pixel_valid is high and i_pixel_ready is low, the column, its indices and the ROM address are held.
module conv_window_fetch #(
   parameter int DATA_WIDTH     = 32,
   parameter int ROWS           = 6,
   parameter int IMG_W          = 8,
   parameter int IMG_H          = 8,
   parameter int STRIDE         = 1,
   parameter int CHANNELS       = 1,
   parameter int ROM_LATENCY    = 0,
   parameter int EXT_ADDR_WIDTH = 8
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              enable,
   input  logic [DATA_WIDTH-1:0]                             data_in,
   output logic [EXT_ADDR_WIDTH-1:0]                         ext_rom_addr,
   output logic [ROWS*DATA_WIDTH-1:0]                        o_pixel_bus,
   output logic                                              o_pixel_valid,
   input  logic                                              i_pixel_ready,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_chan_idx,
   output logic [$clog2(IMG_W)-1:0]                          o_col_idx,
   output logic                                              o_last_col,
   output logic                                              o_done
);

   localparam int AW   = EXT_ADDR_WIDTH;
   localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int COLW = $clog2(IMG_W);
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BW   = $clog2(IMG_H + 1);
   localparam logic [AW-1:0] FRAME = AW'(IMG_W * IMG_H);
   localparam logic [AW-1:0] LINE  = AW'(IMG_W);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_chan;
   logic [BW-1:0]   r_band;
   logic [COLW-1:0] r_col;
   logic [RW-1:0]   r_row;
   logic            r_rearm;

   logic            w_cap_vld;
   logic [RW-1:0]   w_cap_slot;
   logic            w_last_cap;
   logic            w_col_last;

   function automatic logic [AW-1:0] f_addr(input logic [AW-1:0] c, input logic [AW-1:0] b,
                                            input logic [AW-1:0] r, input logic [AW-1:0] k);
      return c * FRAME + (b + r) * LINE + k;
   endfunction

   // Each issued read carries its slot number until its data arrives on data_in.
   generate
      if (ROM_LATENCY == 0) begin : g_lat0
         assign w_cap_vld  = (r_state == S_FETCH);
         assign w_cap_slot = r_row;
      end else begin : g_tag
         logic [ROM_LATENCY-1:0] r_tag_vld;
         logic [RW-1:0]          r_tag_slot [ROM_LATENCY];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_tag_vld <= '0;
               for (int i = 0; i < ROM_LATENCY; i++) r_tag_slot[i] <= '0;
            end else begin
               r_tag_vld[0]  <= (r_state == S_FETCH);
               r_tag_slot[0] <= r_row;
               for (int i = 1; i < ROM_LATENCY; i++) begin
                  r_tag_vld[i]  <= r_tag_vld[i-1];
                  r_tag_slot[i] <= r_tag_slot[i-1];
               end
            end
         end

         assign w_cap_vld  = r_tag_vld[ROM_LATENCY-1];
         assign w_cap_slot = r_tag_slot[ROM_LATENCY-1];
      end
   endgenerate

   assign w_last_cap = w_cap_vld && (w_cap_slot == RW'(ROWS - 1));
   assign w_col_last = (r_col == COLW'(IMG_W - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_chan        <= '0;
         r_band        <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_rearm       <= 1'b0;
         ext_rom_addr  <= '0;
         o_pixel_bus   <= '0;
         o_pixel_valid <= 1'b0;
         o_chan_idx    <= '0;
         o_col_idx     <= '0;
         o_last_col    <= 1'b0;
         o_done        <= 1'b0;
      end else begin
         // Row 0 of the band lands in the most significant slot.
         for (int i = 0; i < ROWS; i++) begin
            if (w_cap_vld && (w_cap_slot == RW'(i)))
               o_pixel_bus[(ROWS-1-i)*DATA_WIDTH +: DATA_WIDTH] <= data_in;
         end

         case (r_state)
            S_IDLE: begin
               if (!enable) begin
                  r_rearm <= 1'b0;
               end else if (!r_rearm) begin
                  r_state      <= S_FETCH;
                  r_chan       <= '0;
                  r_band       <= '0;
                  r_col        <= '0;
                  r_row        <= '0;
                  ext_rom_addr <= '0;
               end
            end

            S_FETCH, S_WAIT: begin
               if (w_last_cap) begin
                  r_state       <= S_OUT;
                  o_pixel_valid <= 1'b1;
                  o_chan_idx    <= r_chan;
                  o_col_idx     <= r_col;
                  o_last_col    <= w_col_last;
               end else if (r_state == S_FETCH) begin
                  if (r_row == RW'(ROWS - 1)) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_row        <= r_row + RW'(1);
                     ext_rom_addr <= f_addr(AW'(r_chan), AW'(r_band), AW'(r_row) + AW'(1), AW'(r_col));
                  end
               end
            end

            S_OUT: begin
               if (i_pixel_ready) begin
                  o_pixel_valid <= 1'b0;
                  r_row         <= '0;
                  if (!w_col_last) begin
                     r_col        <= r_col + COLW'(1);
                     r_state      <= S_FETCH;
                     ext_rom_addr <= f_addr(AW'(r_chan), AW'(r_band), '0, AW'(r_col) + AW'(1));
                  end else if (32'(r_band) + STRIDE + ROWS <= IMG_H) begin
                     r_col        <= '0;
                     r_band       <= r_band + BW'(STRIDE);
                     r_state      <= S_FETCH;
                     ext_rom_addr <= f_addr(AW'(r_chan), AW'(r_band) + AW'(STRIDE), '0, '0);
                  end else if (r_chan != CW'(CHANNELS - 1)) begin
                     r_col        <= '0;
                     r_band       <= '0;
                     r_chan       <= r_chan + CW'(1);
                     r_state      <= S_FETCH;
                     ext_rom_addr <= f_addr(AW'(r_chan) + AW'(1), '0, '0, '0);
                  end else begin
                     r_col   <= '0;
                     r_band  <= '0;
                     r_state <= S_DONE;
                     o_done  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               // One frame per enable-high period: stay parked until enable is seen low.
               o_done  <= 1'b0;
               r_rearm <= 1'b1;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/conv_window_fetch.md
Name: conv_window_fetch

Overview:
- Parametrised pixel-fetch front end for the convolution layer.
- Reads one or more image channels from the external pixel ROM through ext_rom_addr/data_in.
- Assembles vertical columns of ROWS pixels and streams them on o_pixel_bus to the kernel array with a valid/ready handshake.
- Generalises the fixed 6x32-bit column fetch: configurable pixel width, column height, image size, vertical stride, channel count and ROM read latency.

Parameters:
- DATA_WIDTH, 32, bits per pixel.
- ROWS, 6, pixels per output column (kernel rows).
- IMG_W, 8, image width in pixels.
- IMG_H, 8, image height in pixels. Must satisfy ROWS <= IMG_H.
- STRIDE, 1, vertical step between row bands. Range 1..ROWS.
- CHANNELS, 1, number of images stored back to back in the ROM.
- ROM_LATENCY, 0, cycles from ext_rom_addr to valid data_in. Range 0..3.
- EXT_ADDR_WIDTH, 8, ROM address width. Must satisfy CHANNELS*IMG_W*IMG_H <= 2**EXT_ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level start request.
- data_in  in  DATA_WIDTH  ROM read data.
- ext_rom_addr  out  EXT_ADDR_WIDTH  ROM read address.
- o_pixel_bus  out  ROWS*DATA_WIDTH  pixel column; row 0 of the band in the MSBs.
- o_pixel_valid  out  1  o_pixel_bus holds a complete column.
- i_pixel_ready  in  1  downstream accepts the column.
- o_chan_idx  out  max(1,$clog2(CHANNELS))  channel of the current column.
- o_col_idx  out  $clog2(IMG_W)  column index of the current column.
- o_last_col  out  1  current column is the last of its band.
- o_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: synchronous; rst=1 at a clock edge forces all of the following, from any state including mid-frame:
  - FSM to IDLE.
  - ext_rom_addr, o_pixel_bus, o_chan_idx, o_col_idx = 0.
  - o_pixel_valid, o_last_col, o_done = 0.
  - All counters and the rearm flag = 0.
  - In-flight ROM reads are discarded.
- FSM states: IDLE, FETCH, WAIT, OUT, DONE.
- IDLE:
  - Moves to FETCH when enable=1 and rearm=0.
  - Initialises chan=0, band_row=0, col=0.
- FETCH: lasts ROWS cycles. In cycle r (0..ROWS-1): ext_rom_addr = chan*IMG_W*IMG_H + (band_row+r)*IMG_W + col.
- Data capture:
  - The read issued in fetch cycle r is registered into slot r at the clock edge ending cycle r+ROM_LATENCY.
  - A ROM_LATENCY-deep tag shift register tracks outstanding reads.
- WAIT: entered after FETCH when ROM_LATENCY>0; held until the last slot is captured. With ROM_LATENCY=0 the FSM goes directly to OUT.
- OUT timing: o_pixel_valid rises exactly ROWS+ROM_LATENCY cycles after the first FETCH cycle.
- OUT:
  - o_pixel_bus, o_chan_idx, o_col_idx and o_last_col are stable while valid=1 and ready=0.
  - ext_rom_addr holds its last value; no new reads are issued.
  - On valid&ready the column is consumed and valid drops next cycle unless the FSM re-enters OUT.
- Advance on acceptance:
  - If col<IMG_W-1: col+1, FSM to FETCH.
  - Else col=0 and band_row+=STRIDE. If band_row+STRIDE+ROWS <= IMG_H, FSM to FETCH.
  - Else band_row=0 and chan+=1. If chan<CHANNELS-1, FSM to FETCH; otherwise FSM to DONE.
- Band count: bands per channel = (IMG_H-ROWS)/STRIDE+1 (integer division). Remainder rows are never fetched.
- DONE:
  - o_done=1 for exactly one cycle.
  - Sets rearm=1 and FSM returns to IDLE.
  - rearm clears when enable=0 is sampled. One frame per enable high period, no auto-restart.
- Mid-frame enable: dropping enable is ignored; the frame completes.
- Arithmetic: address computed unsigned at EXT_ADDR_WIDTH. Overflow is impossible under the parameter constraint; the bench asserts the constraint at elaboration.
- Parallel capture: data_in is not registered when no read is outstanding.

Test Plan:
1. Defaults, ROM data=address, ready=1, enable=1:
   - First valid 6 cycles after FETCH entry, bus {0,8,16,24,32,40}.
   - 24 columns total; last bus {23,31,39,47,55,63} with o_last_col=1.
   - o_done pulses once.
2. Defaults, ready=0 for 5 cycles at column 3 of band 0:
   - Bus stays {3,11,19,27,35,43}; valid held; ext_rom_addr constant.
   - Next column {4,...} follows after ready returns.
3. ROM_LATENCY=2 with a 2-stage pipelined ROM:
   - First valid 8 cycles after FETCH entry.
   - Identical column sequence to scenario 1.
4. CHANNELS=2:
   - 48 columns; column 24 has o_chan_idx=1, bus {64,72,80,88,96,104}.
   - Final bus {87,95,103,111,119,127}.
5. STRIDE=2:
   - 16 columns; column 8 bus {16,24,32,40,48,56}.
   - Enable held high after o_done: no second frame until enable toggles 0->1.
6. rst=1 for 1 cycle during FETCH of column 5, enable held 1:
   - Next cycle all outputs 0, FSM IDLE.
   - A fresh frame restarts from bus {0,8,16,24,32,40}.
